fpga_config_loader: RTL and testbench

Loads the fabric configuration chain. Accepts configuration words from the host over a valid/ready port and serialises them LSB-first onto the chain whose tail bits drive the per-cell configuration inputs (reset polarity/value, LUT bits, routing selects) of the fabric's tech registers and buffers. After the last bit, it pulses a latch strobe so the shadow registers take the new configuration, then reports done. It sits directly upstream of the fabric's configuration storage.

---
 rtl/fpga_config_pkg.sv | 24 ++
 rtl/fpga_config_crc8.sv | 30 +++
 rtl/fpga_config_loader.sv | 175 +++++++++++++++++
 tb/tb_fpga_config_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_config_pkg.sv
// Shared types and constants for the fabric configuration loader.
// The optional CRC check is compiled in with FPGA_CFG_CRC_EN.
package fpga_config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CRC   = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } cfg_state_e;

  localparam logic [7:0] CFG_CRC_POLY = 8'h07;
  localparam logic [7:0] CFG_CRC_INIT = 8'h00;

  // One serial CRC-8 step: MSB-first register, bit enters at the top.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CFG_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fpga_config_crc8.sv
// Serial bit-in CRC-8 over the configuration stream, with clear and enable.
// Only instantiated by the loader when FPGA_CFG_CRC_EN is defined.
module fpga_config_crc8
  import fpga_config_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] r_crc;

  // Fold one chain bit into the running CRC whenever the chain shifts.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_crc <= CFG_CRC_INIT;
    end else if (clr_i) begin
      r_crc <= CFG_CRC_INIT;
    end else if (en_i) begin
      r_crc <= crc8_step(r_crc, bit_i);
    end
  end

  assign crc_o = r_crc;

endmodule

// File: rtl/fpga_config_loader.sv
// Fabric configuration chain loader: accepts host words over valid/ready,
// shifts them LSB-first into the chain, then strobes the shadow latch.
// Define FPGA_CFG_CRC_EN to add a trailing CRC-8 word check before latching.
module fpga_config_loader
  import fpga_config_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              cfg_data_o,
  output logic              cfg_shift_o,
  output logic              cfg_latch_o,
  output logic              cfg_busy_o,
  output logic              cfg_done_o,
  output logic              cfg_error_o
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  cfg_state_e        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [WORD_W-1:0] r_shreg;
  logic              r_ready;
  logic              r_data;
  logic              r_shift;
  logic              r_latch;
  logic              r_busy;
  logic              r_done;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic              w_start_ok;

  // A start request only counts while the loader is idle or finished.
  assign w_start_ok  = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_shreg_nxt = r_shreg >> 1;

`ifdef FPGA_CFG_CRC_EN
  logic       r_error;
  logic [7:0] w_crc;

  fpga_config_crc8 u_crc (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (w_start_ok),
    .en_i   (r_shift),
    .bit_i  (r_data),
    .crc_o  (w_crc)
  );
`endif

  // Load sequencer; outputs are registered alongside each state transition.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_ready   <= 1'b0;
      r_data    <= 1'b0;
      r_shift   <= 1'b0;
      r_latch   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef FPGA_CFG_CRC_EN
      r_error   <= 1'b0;
`endif
    end else begin
      r_latch <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_state   <= ST_LOAD;
            r_bit_cnt <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
`ifdef FPGA_CFG_CRC_EN
            r_error   <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          if (word_valid_i) begin
            r_state   <= ST_SHIFT;
            r_shreg   <= word_i;
            r_bit_idx <= '0;
            r_ready   <= 1'b0;
            r_shift   <= 1'b1;
            r_data    <= word_i[0];
          end
        end

        ST_SHIFT: begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          r_shreg   <= w_shreg_nxt;
          if (r_bit_cnt == LAST_BIT) begin
            // Chain full: any remaining bits of this word are dropped.
            r_shift <= 1'b0;
            r_data  <= 1'b0;
`ifdef FPGA_CFG_CRC_EN
            r_state <= ST_CRC;
            r_ready <= 1'b1;
`else
            r_state <= ST_LATCH;
            r_latch <= 1'b1;
`endif
          end else if (r_bit_idx == LAST_IDX) begin
            r_state <= ST_LOAD;
            r_shift <= 1'b0;
            r_data  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_bit_idx <= r_bit_idx + IDX_W'(1);
            r_data    <= w_shreg_nxt[0];
          end
        end

`ifdef FPGA_CFG_CRC_EN
        ST_CRC: begin
          if (word_valid_i) begin
            r_ready <= 1'b0;
            if (word_i[7:0] == w_crc) begin
              r_state <= ST_LATCH;
              r_latch <= 1'b1;
            end else begin
              // Bad image: finish without touching the shadow configuration.
              r_state <= ST_DONE;
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
`endif

        ST_LATCH: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_shift <= 1'b0;
          r_data  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready_o = r_ready;
  assign cfg_data_o   = r_data;
  assign cfg_shift_o  = r_shift;
  assign cfg_latch_o  = r_latch;
  assign cfg_busy_o   = r_busy;
  assign cfg_done_o   = r_done;
`ifdef FPGA_CFG_CRC_EN
  assign cfg_error_o  = r_error;
`else
  assign cfg_error_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomized self-checking bench for fpga_config_loader (CHAIN_LEN=20, WORD_W=8).
// The reference model derives the chain image from the word list directly.
module tb_fpga_config_loader;

  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;
  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef FPGA_CFG_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic              clk;
  logic              rstn_i;
  logic              start_i;
  logic [WORD_W-1:0] word_i;
  logic              word_valid_i;
  logic              word_ready_o;
  logic              cfg_data_o;
  logic              cfg_shift_o;
  logic              cfg_latch_o;
  logic              cfg_busy_o;
  logic              cfg_done_o;
  logic              cfg_error_o;

  fpga_config_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .start_i      (start_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .cfg_data_o   (cfg_data_o),
    .cfg_shift_o  (cfg_shift_o),
    .cfg_latch_o  (cfg_latch_o),
    .cfg_busy_o   (cfg_busy_o),
    .cfg_done_o   (cfg_done_o),
    .cfg_error_o  (cfg_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state: the fabric side of the chain, rebuilt from observed pins.
  logic [CHAIN_LEN-1:0] chain  = '0;
  logic [CHAIN_LEN-1:0] shadow = '0;
  bit                   obs_q[$];
  int                   acc_cnt = 0;
  int                   latch_cnt = 0;
  int                   cyc = 0;
  int                   latch_cyc = -100;
  int                   done_rise_cyc = -200;
  bit                   prev_acc = 1'b0;
  bit                   prev_done = 1'b0;

  logic [WORD_W-1:0]    tx_q[$];
  logic [CHAIN_LEN-1:0] last_obs;
  logic [CHAIN_LEN-1:0] saved_shadow;

  // Sample pins mid-cycle and model the chain and its shadow copy.
  always @(negedge clk) begin
    cyc++;
    if (rstn_i) begin
      if (prev_acc) check("shift_after_accept", cfg_shift_o, 1'b1);
      if (cfg_shift_o) begin
        obs_q.push_back(cfg_data_o);
        chain = {cfg_data_o, chain[CHAIN_LEN-1:1]};
        check("ready_low_in_shift", word_ready_o, 1'b0);
      end else begin
        check("data_zero_outside_shift", cfg_data_o, 1'b0);
      end
      if (cfg_latch_o) begin
        latch_cnt++;
        shadow    = chain;
        latch_cyc = cyc;
      end
      if (cfg_done_o && !prev_done) done_rise_cyc = cyc;
      prev_acc  = word_valid_i && word_ready_o;
      if (prev_acc) acc_cnt++;
      prev_done = cfg_done_o;
    end else begin
      prev_acc  = 1'b0;
      prev_done = 1'b0;
    end
  end

  function automatic logic [7:0] crc_ref(input logic [CHAIN_LEN-1:0] bits);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic random_words();
    tx_q.delete();
    for (int i = 0; i < N_WORDS; i++) tx_q.push_back(WORD_W'($urandom));
  endtask

  // Pulse start_i while the loader is shifting and while it is latching.
  task automatic disturb_starts();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (cfg_shift_o) seen = 1'b1;
    end
    if (seen) begin
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (cfg_latch_o) seen = 1'b1;
    end
    if (seen) begin
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
    end
  endtask

  task automatic wait_ready();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      if (word_ready_o) got = 1'b1;
    end
    check("ready_timeout", got, 1'b1);
  endtask

  // stall: 0 = valid held high, >0 = fixed idle cycles in LOAD, <0 = random 0..3.
  task automatic do_load(input int stall, input bit extra, input bit bad_crc, input bit disturb);
    logic [WORD_W-1:0]    send_q[$];
    logic [WORD_W-1:0]    w;
    logic [CHAIN_LEN-1:0] exp_bits;
    logic [CHAIN_LEN-1:0] obs_bits;
    logic [CHAIN_LEN-1:0] prev_shadow;
    logic [7:0]           exp_crc;
    bit                   got;
    bit                   exp_err;
    int                   exp_latch;
    int                   nst;

    for (int i = 0; i < CHAIN_LEN; i++) begin
      w = tx_q[i / WORD_W];
      exp_bits[i] = w[i % WORD_W];
    end
    exp_crc = crc_ref(exp_bits);
    send_q  = tx_q;
    if (CRC_ON) send_q.push_back(WORD_W'(bad_crc ? (exp_crc ^ 8'h01) : exp_crc));
    exp_err   = CRC_ON && bad_crc;
    exp_latch = exp_err ? 0 : 1;
    prev_shadow = shadow;

    obs_q.delete();
    acc_cnt       = 0;
    latch_cnt     = 0;
    latch_cyc     = -100;
    done_rise_cyc = -200;

    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    check("after_start", {cfg_done_o, cfg_error_o, word_ready_o, cfg_busy_o}, 4'b0011);

    if (disturb) begin
      fork
        disturb_starts();
      join_none
    end

    for (int k = 0; k < send_q.size(); k++) begin
      if (stall != 0) begin
        word_valid_i = 1'b0;
        wait_ready();
        nst = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
        for (int s = 0; s < nst; s++) begin
          @(negedge clk);
          check("stall_in_load", {word_ready_o, cfg_shift_o, cfg_busy_o}, 3'b101);
        end
        @(posedge clk);
        #1;
      end
      word_i       = send_q[k];
      word_valid_i = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 64 && !got; t++) begin
        @(negedge clk);
        if (word_ready_o) begin
          @(posedge clk);
          #1 got = 1'b1;
        end
      end
      check("accept_timeout", got, 1'b1);
      if (stall != 0) word_valid_i = 1'b0;
    end

    if (extra) begin
      word_i       = WORD_W'($urandom);
      word_valid_i = 1'b1;
    end else begin
      word_valid_i = 1'b0;
    end

    got = 1'b0;
    for (int t = 0; t < 4 * CHAIN_LEN + 64 && !got; t++) begin
      @(negedge clk);
      if (cfg_done_o) got = 1'b1;
    end
    check("done_timeout", got, 1'b1);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("done_hold", {cfg_done_o, cfg_busy_o, word_ready_o, cfg_latch_o}, 4'b1000);
    end
    @(posedge clk);
    #1 word_valid_i = 1'b0;

    obs_bits = '0;
    for (int i = 0; i < obs_q.size() && i < CHAIN_LEN; i++) obs_bits[i] = obs_q[i];
    last_obs = obs_bits;
    check("shift_cycles", 64'(obs_q.size()), 64'(CHAIN_LEN));
    check("chain_bits", 64'(obs_bits), 64'(exp_bits));
    check("words_accepted", 64'(acc_cnt), 64'(send_q.size()));
    check("latch_pulses", 64'(latch_cnt), 64'(exp_latch));
    check("error_flag", cfg_error_o, exp_err);
    check("shadow", 64'(shadow), 64'(exp_latch != 0 ? exp_bits : prev_shadow));
    if (exp_latch != 0) check("done_after_latch", 64'(done_rise_cyc - latch_cyc), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn_i       = 1'b0;
    start_i      = 1'b0;
    word_i       = '0;
    word_valid_i = 1'b0;
    #12;
    check("reset_outputs",
          {word_ready_o, cfg_data_o, cfg_shift_o, cfg_latch_o, cfg_busy_o, cfg_done_o, cfg_error_o},
          7'b0);
    @(negedge clk);
    rstn_i = 1'b1;

    // Directed: last word truncated, fourth word never accepted.
    tx_q.delete();
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hF5);
    do_load(0, 1'b1, 1'b0, 1'b0);
    check("tail_bits", 64'(last_obs[19:16]), 64'(4'b0101));
    saved_shadow = shadow;

    // Same image with a stalling host gives the same shadow content.
    do_load(5, 1'b0, 1'b0, 1'b0);
    check("stall_same_shadow", 64'(shadow), 64'(saved_shadow));

    // start_i during SHIFT and LATCH is ignored.
    random_words();
    do_load(0, 1'b0, 1'b0, 1'b1);

    // Reset mid-shift: outputs drop at once and no latch happens.
    saved_shadow = shadow;
    random_words();
    latch_cnt = 0;
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    word_i       = tx_q[0];
    word_valid_i = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 word_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("shifting_before_reset", cfg_shift_o, 1'b1);
    #2 rstn_i = 1'b0;
    #1;
    check("reset_mid_shift",
          {word_ready_o, cfg_data_o, cfg_shift_o, cfg_latch_o, cfg_busy_o, cfg_done_o, cfg_error_o},
          7'b0);
    repeat (2) @(negedge clk);
    check("no_latch_on_reset", 64'(latch_cnt), 64'(0));
    check("shadow_kept_on_reset", 64'(shadow), 64'(saved_shadow));
    rstn_i = 1'b1;
    random_words();
    do_load(0, 1'b0, 1'b0, 1'b0);

    // Randomized loads, each started from DONE.
    for (int r = 0; r < 6; r++) begin
      random_words();
      do_load(($urandom_range(1, 0) == 0) ? 0 : -1, 1'($urandom_range(1, 0)), 1'b0, 1'b0);
    end

`ifdef FPGA_CFG_CRC_EN
    // Corrupted CRC word: error and done, no latch, shadow untouched.
    random_words();
    do_load(0, 1'b0, 1'b1, 1'b0);
    random_words();
    do_load(-1, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
